// File: rtl/sound_event_scheduler_if.sv
// ---------------------------------------------------------------------------
// sound_event_scheduler_if
// Bundles the event-request inputs and the tone-side outputs of the sound
// event scheduler.
//   master : game-logic side; drives enableSound and req, observes status
//   slave  : scheduler side; samples enableSound/req, drives the outputs
// Signals:
//   enableSound  global sound enable (level)
//   req          one-cycle event pulses, bit i = source i
//   enable_out   tone generator enable
//   tone         tone code (source index + 1, 0 = silence)
//   busy         scheduler has work in flight
//   queue_count  FIFO occupancy
//   dropped      one-cycle pulse when a request was coalesced or discarded
// ---------------------------------------------------------------------------
interface sound_event_scheduler_if #(
  parameter int NUM_SRC     = 8,
  parameter int QUEUE_DEPTH = 4
);
  logic                         enableSound;
  logic [NUM_SRC-1:0]           req;
  logic                         enable_out;
  logic [3:0]                   tone;
  logic                         busy;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;
  logic                         dropped;

  modport master (
    output enableSound, req,
    input  enable_out, tone, busy, queue_count, dropped
  );

  modport slave (
    input  enableSound, req,
    output enable_out, tone, busy, queue_count, dropped
  );
endinterface

// File: rtl/sound_event_scheduler.sv
// ---------------------------------------------------------------------------
// sound_event_scheduler
// Turns one-cycle game event pulses into a sequence of fixed-length tones
// separated by a fixed silent gap. Requests are latched in a pending vector
// (one bit per source, so repeats coalesce), moved one per cycle into a small
// FIFO in source-index order, and played by an IDLE/PLAY/GAP sequencer.
// Sources in PREEMPT_MASK bypass everything and start immediately.
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset
//   bus     scheduler side (slave modport) of sound_event_scheduler_if
// ---------------------------------------------------------------------------
module sound_event_scheduler #(
  parameter int                 NUM_SRC      = 8,
  parameter int                 QUEUE_DEPTH  = 4,
  parameter int                 TONE_CYCLES  = 25_000_000,
  parameter int                 GAP_CYCLES   = 2_500_000,
  parameter logic [NUM_SRC-1:0] PREEMPT_MASK = NUM_SRC'(4)
) (
  input  logic                  clk,
  input  logic                  resetN,
  sound_event_scheduler_if.slave bus
);

  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam int TMAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  // The timer only ever holds a load value, i.e. at most TMAX-1.
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] TONE_LOAD  = TW'(TONE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [3:0]         tone_q, tone_d;
  logic               enable_q, enable_d;
  logic               dropped_q, dropped_d;

  logic [3:0]         fifo_mem [QUEUE_DEPTH];

  logic [NUM_SRC-1:0] normal_req, preempt_req, pend_lowest, preempt_lowest, push_onehot;
  logic [3:0]         pend_terms [NUM_SRC];
  logic [3:0]         preempt_terms [NUM_SRC];
  logic [3:0]         pend_code, preempt_code, fifo_head;
  logic               push, pop, fifo_full, fifo_empty;

  assign normal_req  = bus.req & ~PREEMPT_MASK;
  assign preempt_req = bus.req & PREEMPT_MASK;

  // v & -v isolates the lowest set bit: fixed priority by source index.
  assign pend_lowest    = pending_q & (~pending_q + NUM_SRC'(1));
  assign preempt_lowest = preempt_req & (~preempt_req + NUM_SRC'(1));

  // One-hot to tone code (index + 1); the inputs are one-hot so OR is exact.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_enc
    assign pend_terms[gi]    = pend_lowest[gi]    ? 4'(gi + 1) : 4'd0;
    assign preempt_terms[gi] = preempt_lowest[gi] ? 4'(gi + 1) : 4'd0;
  end

  always_comb begin
    pend_code    = '0;
    preempt_code = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_code    = pend_code | pend_terms[i];
      preempt_code = preempt_code | preempt_terms[i];
    end
  end

  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    timer_d     = timer_q;
    tone_d      = tone_q;
    enable_d    = enable_q;
    dropped_d   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    push_onehot = '0;

    if (!bus.enableSound) begin
      // Muted: drop everything, requests are not even looked at.
      state_d   = S_IDLE;
      pending_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      timer_d   = '0;
      tone_d    = '0;
      enable_d  = 1'b0;
    end else if (|preempt_req) begin
      // Preempt wins in any state; losers and same-cycle normal requests
      // are discarded and reported.
      state_d   = S_PLAY;
      pending_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      timer_d   = TONE_LOAD;
      tone_d    = preempt_code;
      enable_d  = 1'b1;
      dropped_d = (|(preempt_req & ~preempt_lowest)) | (|normal_req);
    end else begin
      push        = (|pending_q) && !fifo_full;
      push_onehot = push ? pend_lowest : '0;
      pending_d   = (pending_q & ~push_onehot) | normal_req;
      // A request only coalesces if its bit is still pending after this edge.
      dropped_d   = |(normal_req & pending_q & ~push_onehot);

      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            tone_d   = fifo_head;
            enable_d = 1'b1;
            timer_d  = TONE_LOAD;
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (timer_q == '0) begin
            if (GAP_CYCLES > 0) begin
              enable_d = 1'b0;
              tone_d   = '0;
              timer_d  = GAP_LOAD;
              state_d  = S_GAP;
            end else if (!fifo_empty) begin
              // No gap configured: chain straight into the next tone.
              pop     = 1'b1;
              tone_d  = fifo_head;
              timer_d = TONE_LOAD;
            end else begin
              enable_d = 1'b0;
              tone_d   = '0;
              state_d  = S_IDLE;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_GAP: begin
          if (timer_q == '0) begin
            if (!fifo_empty) begin
              pop      = 1'b1;
              tone_d   = fifo_head;
              enable_d = 1'b1;
              timer_d  = TONE_LOAD;
              state_d  = S_PLAY;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      tone_q    <= '0;
      enable_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      tone_q    <= tone_d;
      enable_q  <= enable_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pend_code;
  end

  assign bus.enable_out  = enable_q;
  assign bus.tone        = tone_q;
  assign bus.busy        = (state_q != S_IDLE) || (count_q != '0) || (|pending_q);
  assign bus.queue_count = count_q;
  assign bus.dropped     = dropped_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sound_event_scheduler
// Two scheduler instances share clock, reset and stimulus: instance 0 has a
// 2-cycle gap, instance 1 has no gap. Each is compared every cycle against a
// timestamp-based behavioural model (tone end times, a queue of tone codes, a
// pending bit set). Directed scenarios add fixed expectations on top.
// ---------------------------------------------------------------------------
module tb_sound_event_scheduler;

  localparam int          T    = 4;
  localparam logic [7:0]  MASK = 8'h04;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       en_drv = 1'b1;
  logic [7:0] req_drv = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_event_scheduler_if #(.NUM_SRC(8), .QUEUE_DEPTH(4)) ifa ();
  sound_event_scheduler_if #(.NUM_SRC(8), .QUEUE_DEPTH(4)) ifb ();

  assign ifa.enableSound = en_drv;
  assign ifa.req         = req_drv;
  assign ifb.enableSound = en_drv;
  assign ifb.req         = req_drv;

  sound_event_scheduler #(
    .NUM_SRC(8), .QUEUE_DEPTH(4), .TONE_CYCLES(T), .GAP_CYCLES(2), .PREEMPT_MASK(MASK)
  ) dut_a (.clk(clk), .resetN(resetN), .bus(ifa.slave));

  sound_event_scheduler #(
    .NUM_SRC(8), .QUEUE_DEPTH(4), .TONE_CYCLES(T), .GAP_CYCLES(0), .PREEMPT_MASK(MASK)
  ) dut_b (.clk(clk), .resetN(resetN), .bus(ifb.slave));

  // {enable_out, tone, busy, queue_count, dropped}
  logic [9:0] obs [2];
  assign obs[0] = {ifa.enable_out, ifa.tone, ifa.busy, ifa.queue_count, ifa.dropped};
  assign obs[1] = {ifb.enable_out, ifb.tone, ifb.busy, ifb.queue_count, ifb.dropped};

  // ------------------------------------------------------------------
  // Behavioural model. A segment (tone or gap) is described by the edge
  // at which it ends; m_end < 0 means idle.
  // ------------------------------------------------------------------
  longint     cyc = 0;
  int         m_tone [2];
  longint     m_end  [2];
  logic [7:0] m_pend [2];
  logic       m_drop [2];
  int         mq [2][$];

  function automatic int gap_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_tone[k] = 0;
      m_end[k]  = -1;
      m_pend[k] = '0;
      m_drop[k] = 1'b0;
      mq[k].delete();
    end
  endtask

  task automatic model_step(int k, logic en, logic [7:0] r);
    logic [7:0] pre;
    logic [7:0] pushed;
    bit         full;
    int         w;
    pre       = r & MASK;
    pushed    = '0;
    m_drop[k] = 1'b0;
    if (!en) begin
      m_tone[k] = 0;
      m_end[k]  = -1;
      m_pend[k] = '0;
      mq[k].delete();
      return;
    end
    if (pre != 0) begin
      w         = lowest(pre);
      m_drop[k] = ((pre & ~(8'h01 << w)) != 0) || ((r & ~MASK) != 0);
      m_pend[k] = '0;
      mq[k].delete();
      m_tone[k] = w + 1;
      m_end[k]  = cyc + T;
      return;
    end
    full = (mq[k].size() >= 4);
    if (m_tone[k] != 0 && cyc == m_end[k]) begin
      if (gap_of(k) > 0) begin
        m_tone[k] = 0;
        m_end[k]  = cyc + gap_of(k);
      end else if (mq[k].size() > 0) begin
        m_tone[k] = mq[k].pop_front();
        m_end[k]  = cyc + T;
      end else begin
        m_tone[k] = 0;
        m_end[k]  = -1;
      end
    end else if (m_tone[k] == 0 && (m_end[k] < 0 || cyc == m_end[k])) begin
      if (mq[k].size() > 0) begin
        m_tone[k] = mq[k].pop_front();
        m_end[k]  = cyc + T;
      end else begin
        m_end[k] = -1;
      end
    end
    if (!full && m_pend[k] != 0) begin
      w      = lowest(m_pend[k]);
      pushed = 8'h01 << w;
      mq[k].push_back(w + 1);
    end
    m_drop[k] = ((r & ~MASK & m_pend[k] & ~pushed) != 0);
    m_pend[k] = (m_pend[k] & ~pushed) | (r & ~MASK);
  endtask

  function automatic logic [9:0] exp_vec(int k);
    logic b;
    b = (m_end[k] >= 0) || (mq[k].size() != 0) || (m_pend[k] != 0);
    return {m_tone[k] != 0, 4'(m_tone[k]), b, 3'(mq[k].size()), m_drop[k]};
  endfunction

  // One clock edge: model consumes the inputs the DUTs sample at that edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k, en_drv, req_drv);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    resetN = 1'b0; en_drv = 1'b1; req_drv = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 10'h000) begin
        errors++;
        $display("FAIL reset_values inst=%0d got=%b exp=%b", k, obs[k], 10'h000);
      end
    end
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    int rise_at = -1;
    int high = 0;
    for (int c = 0; c < 13; c++) begin
      req_drv = (c == 0) ? 8'h02 : 8'h00;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL single inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (ifa.enable_out === 1'b1) begin
        if (rise_at < 0) rise_at = c;
        if (ifa.tone === 4'd2) high++;
      end
    end
    checks++;
    if (rise_at != 2) begin
      errors++;
      $display("FAIL single_latency got edge %0d exp edge 2", rise_at);
    end
    checks++;
    if (high != 4) begin
      errors++;
      $display("FAIL single_length got %0d cycles of tone 2 exp 4", high);
    end
    checks++;
    if (ifa.busy !== 1'b0 || ifa.enable_out !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b en=%b exp 0/0", ifa.busy, ifa.enable_out);
    end
  endtask

  task automatic test_same_cycle();
    int   starts[$];
    int   drops = 0;
    logic prev_en = 1'b0;
    for (int c = 0; c < 22; c++) begin
      req_drv = (c == 0) ? 8'h28 : 8'h00;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL same_cycle inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (ifa.enable_out === 1'b1 && !prev_en) starts.push_back(int'(ifa.tone));
      if (ifa.dropped === 1'b1) drops++;
      prev_en = ifa.enable_out;
    end
    checks++;
    if (starts.size() != 2 || starts[0] != 4 || starts[1] != 6) begin
      errors++;
      $display("FAIL same_cycle_order got %0d tones (first %0d) exp tones 4 then 6",
               starts.size(), (starts.size() > 0) ? starts[0] : -1);
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL same_cycle_dropped got %0d pulses exp 0", drops);
    end
  endtask

  task automatic test_coalesce();
    logic [7:0] stim [5] = '{8'h80, 8'h00, 8'h00, 8'h03, 8'h02};
    int   drops = 0;
    int   tone2_starts = 0;
    logic prev_en = 1'b0;
    for (int c = 0; c < 30; c++) begin
      req_drv = (c < 5) ? stim[c] : 8'h00;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL coalesce inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (ifa.dropped === 1'b1) drops++;
      if (ifa.enable_out === 1'b1 && !prev_en && ifa.tone === 4'd2) tone2_starts++;
      prev_en = ifa.enable_out;
    end
    checks++;
    if (drops != 1) begin
      errors++;
      $display("FAIL coalesce_dropped got %0d pulses exp 1", drops);
    end
    checks++;
    if (tone2_starts != 1) begin
      errors++;
      $display("FAIL coalesce_once got %0d plays of tone 2 exp 1", tone2_starts);
    end
  endtask

  task automatic test_saturate();
    int   exp_order [7] = '{8, 1, 2, 4, 5, 6, 7};
    int   starts[$];
    int   max_qc = 0;
    logic prev_en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      req_drv = (c == 0) ? 8'h80 : (c == 1) ? 8'h7B : 8'h00;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL saturate inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (int'(ifa.queue_count) > max_qc) max_qc = int'(ifa.queue_count);
      if (ifa.enable_out === 1'b1 && !prev_en) starts.push_back(int'(ifa.tone));
      prev_en = ifa.enable_out;
    end
    checks++;
    if (max_qc != 4) begin
      errors++;
      $display("FAIL saturate_depth got max queue_count %0d exp 4", max_qc);
    end
    checks++;
    if (starts.size() != 7) begin
      errors++;
      $display("FAIL saturate_count got %0d tones exp 7", starts.size());
    end
    for (int i = 0; i < 7 && i < starts.size(); i++) begin
      checks++;
      if (starts[i] != exp_order[i]) begin
        errors++;
        $display("FAIL saturate_order slot %0d got tone %0d exp %0d", i, starts[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_preempt();
    logic [7:0] stim [6] = '{8'h80, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h04};
    int high = 0;
    for (int c = 0; c < 16; c++) begin
      req_drv = (c < 6) ? stim[c] : 8'h00;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL preempt inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (c == 4) begin
        checks++;
        if (ifa.queue_count !== 3'd3 || ifa.tone !== 4'd8) begin
          errors++;
          $display("FAIL preempt_setup got qc=%0d tone=%0d exp qc=3 tone=8", ifa.queue_count, ifa.tone);
        end
      end
      if (c == 5) begin
        checks++;
        if (ifa.tone !== 4'd3 || ifa.enable_out !== 1'b1 || ifa.queue_count !== 3'd0) begin
          errors++;
          $display("FAIL preempt_edge got tone=%0d en=%b qc=%0d exp tone=3 en=1 qc=0",
                   ifa.tone, ifa.enable_out, ifa.queue_count);
        end
      end
      if (c >= 5 && ifa.enable_out === 1'b1) high++;
    end
    checks++;
    if (high != 4 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_length got %0d cycles busy=%b exp 4 cycles busy=0", high, ifa.busy);
    end
  endtask

  task automatic test_disable();
    // {enableSound, req}
    logic [8:0] stim [6] = '{9'h180, 9'h103, 9'h100, 9'h100, 9'h000, 9'h002};
    int late_high = 0;
    int late_drop = 0;
    for (int c = 0; c < 14; c++) begin
      {en_drv, req_drv} = (c < 6) ? stim[c] : 9'h100;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL disable inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (c == 3) begin
        checks++;
        if (ifa.queue_count !== 3'd2 || ifa.enable_out !== 1'b1) begin
          errors++;
          $display("FAIL disable_setup got qc=%0d en=%b exp qc=2 en=1", ifa.queue_count, ifa.enable_out);
        end
      end
      if (c == 4) begin
        checks++;
        if (ifa.enable_out !== 1'b0 || ifa.tone !== 4'd0 || ifa.queue_count !== 3'd0) begin
          errors++;
          $display("FAIL disable_flush got en=%b tone=%0d qc=%0d exp 0/0/0",
                   ifa.enable_out, ifa.tone, ifa.queue_count);
        end
      end
      if (c >= 4 && ifa.enable_out === 1'b1) late_high++;
      if (c >= 4 && ifa.dropped === 1'b1) late_drop++;
    end
    checks++;
    if (late_high != 0 || late_drop != 0) begin
      errors++;
      $display("FAIL disable_ignore got %0d tone cycles %0d drops exp 0/0", late_high, late_drop);
    end
  endtask

  task automatic test_gap0();
    int   high = 0;
    int   rises = 0;
    int   tone2 = 0;
    logic prev_en = 1'b0;
    for (int c = 0; c < 14; c++) begin
      req_drv = (c == 0) ? 8'h03 : 8'h00;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL gap0 inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (ifb.enable_out === 1'b1) high++;
      if (ifb.enable_out === 1'b1 && !prev_en) rises++;
      if (ifb.tone === 4'd2) tone2++;
      prev_en = ifb.enable_out;
    end
    checks++;
    if (high != 8 || rises != 1 || tone2 != 4) begin
      errors++;
      $display("FAIL gap0_chain got high=%0d rises=%0d tone2=%0d exp 8/1/4", high, rises, tone2);
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) begin
      req_drv = (c == 0) ? 8'h80 : 8'h00;
      tick();
    end
    checks++;
    if (ifa.enable_out !== 1'b1) begin
      errors++;
      $display("FAIL async_setup got en=%b exp 1", ifa.enable_out);
    end
    resetN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 10'h000) begin
        errors++;
        $display("FAIL async_reset inst=%0d got=%b exp=%b", k, obs[k], 10'h000);
      end
    end
    model_reset();
    #1;
    resetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL async_after inst=%0d cyc=%0d got=%b exp=%b", k, cyc, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) r = 8'h00;
      else r = r & 8'($urandom_range(0, 255));
      if ($urandom_range(0, 24) != 0) r[2] = 1'b0;
      req_drv = r;
      en_drv  = ($urandom_range(0, 49) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random inst=%0d cyc=%0d req=%h en=%b got=%b exp=%b",
                   k, cyc, req_drv, en_drv, obs[k], exp_vec(k));
        end
      end
    end
    req_drv = '0;
    en_drv  = 1'b0;
    tick();
    en_drv  = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_coalesce();
    test_saturate();
    test_preempt();
    test_disable();
    test_gap0();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_event_scheduler.md
Name: sound_event_scheduler

Overview:
Queues and sequences game sound events (hit, level-up, game-over, pickup, shoot, ...) ahead of the tone generator. Each event plays for a fixed duration, followed by a silent gap. Events are never lost to overlap, only coalesced. Selected sources can preempt everything else. Sits between game-logic event pulses and the tone decoder/audio DAC path.

Parameters:
NUM_SRC, 8, number of request sources; valid range 1..15.
QUEUE_DEPTH, 4, FIFO entries; power of 2, at least 2.
TONE_CYCLES, 25_000_000, enable_out high time per tone, in clk cycles; at least 1.
GAP_CYCLES, 2_500_000, silent cycles between consecutive queued tones; 0 is allowed.
PREEMPT_MASK, 8'b0000_0100, bit i set means source i preempts.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous, active-low reset
enableSound  in  1  global sound enable (level)
req  in  NUM_SRC  one-cycle event pulses; bit i is source i
enable_out  out  1  tone generator enable
tone  out  4  tone code: source index + 1; 0 means silence
busy  out  1  high when state is not IDLE, or the FIFO/pending vector is non-empty
queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy
dropped  out  1  one-cycle pulse when a request is coalesced or discarded

Behaviour:
Reset values:
- enable_out=0, tone=0, busy=0, queue_count=0, dropped=0.
- State=IDLE; pending vector, FIFO and timer all cleared.

Request capture:
- Applies to non-preempt sources only.
- pending_next = (pending & ~push_onehot) | (req & ~PREEMPT_MASK).
- dropped=1 on the next cycle if any req bit hits a pending bit that is not being pushed in the same cycle.

Push:
- Each cycle, if the FIFO is not full, the lowest-index pending bit is pushed and cleared.
- If the FIFO is full, pending holds and nothing is lost.
- Push and pop in the same cycle are legal; queue_count is unchanged.

State machine: IDLE, PLAY, GAP.
- IDLE: if the FIFO is non-empty, pop; tone<=entry; enable_out<=1; timer<=TONE_CYCLES-1; go to PLAY.
- PLAY: decrement timer. At 0:
  - If GAP_CYCLES>0: enable_out<=0, tone<=0, timer<=GAP_CYCLES-1, go to GAP.
  - Else if the FIFO is non-empty: pop directly and reload for PLAY; enable_out stays 1 and tone changes.
  - Else: go to IDLE with enable_out=0, tone=0.
- GAP: decrement timer. At 0: pop and enter PLAY if the FIFO is non-empty, else go to IDLE.

Timing:
- enable_out is high for exactly TONE_CYCLES cycles per tone.
- Silence between queued tones is exactly GAP_CYCLES cycles.
- Latency for a non-preempt request sampled at edge E0 into an idle, empty scheduler: pending set after E0, FIFO entry after E1, enable_out=1 after E2.

Preemption (any req bit in PREEMPT_MASK):
- The lowest-index preempt bit wins, in any state.
- Same edge: FIFO and pending flushed; tone<=winner+1; enable_out<=1; timer<=TONE_CYCLES-1; state=PLAY.
- Other simultaneous preempt bits are discarded, with dropped=1 next cycle.
- Non-preempt req bits arriving in the same cycle are also discarded, with dropped=1 next cycle.
- A preempt arriving during a preempt tone restarts the tone.

enableSound=0:
- req is ignored (no capture, no dropped pulse).
- FIFO, pending and timer are flushed; enable_out<=0, tone<=0, state=IDLE, all on the next edge.
- Priority: reset > enableSound=0 > preempt > normal sequencing.

Asynchronous reset mid-tone forces all reset values immediately.

Test Plan:
Use TONE_CYCLES=4, GAP_CYCLES=2, NUM_SRC=8, QUEUE_DEPTH=4, PREEMPT_MASK=8'h04 unless a scenario says otherwise.
1. Single req[1] pulse at E0 -> enable_out=1, tone=2 from after E2 for exactly 4 cycles; then tone=0, enable_out=0; busy=0 after that.
2. req[5] and req[3] in the same cycle -> tone 4 plays (4 cycles), then 2 gap cycles, then tone 6 (4 cycles); dropped stays 0.
3. req[1] pulsed twice, 1 cycle apart, while tone 8 plays -> second pulse coalesces, dropped=1 for one cycle, tone 2 plays once.
4. Six distinct non-preempt requests during a tone -> queue_count saturates at 4, 2 remain pending, all six tones play in index order with no loss.
5. req[2] (preempt) mid-tone with 3 entries queued -> same edge: tone=3, enable_out=1, queue_count=0; plays 4 cycles then IDLE.
6. enableSound deasserted mid-PLAY with 2 queued -> next edge: enable_out=0, tone=0, queue_count=0; req[1] while disabled produces no tone. Repeat with GAP_CYCLES=0 -> back-to-back tones, enable_out never drops between them.
